uart_tx: RTL and testbench



---
 rtl/uart_tx.sv | 145 ++++++++++++++
 tb/tb_uart_tx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8-bit UART transmitter: start bit, 8 data bits LSB first, optional parity, one stop bit.
// Bit timing matches the companion receiver so the pair can be looped back directly.
module uart_tx #(
  parameter int unsigned BASE_FREQ  = 50_000_000,
  parameter int unsigned BAUDRATE   = 115_200,
  parameter bit          PARITY_EN  = 1'b1,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] data_in,
  output logic       serial_out,
  output logic       busy,
  output logic       tx_done
);

  localparam int unsigned CPB   = BASE_FREQ / BAUDRATE;
  localparam int unsigned CNT_W = $clog2(CPB);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift, shift_n;
  logic             par_bit, par_bit_n;
  logic             serial_out_n, busy_n, tx_done_n;
  logic             cell_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
      serial_out <= 1'b1;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_idx_n;
      shift      <= shift_n;
      par_bit    <= par_bit_n;
      serial_out <= serial_out_n;
      busy       <= busy_n;
      tx_done    <= tx_done_n;
    end
  end

  assign cell_end = (cnt == CNT_LAST);

  // Outputs are computed one cycle ahead so the line changes exactly on each bit boundary.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    bit_idx_n    = bit_idx;
    shift_n      = shift;
    par_bit_n    = par_bit;
    serial_out_n = serial_out;
    busy_n       = busy;
    tx_done_n    = 1'b0;
    case (state)
      IDLE: begin
        serial_out_n = 1'b1;
        busy_n       = 1'b0;
        cnt_n        = '0;
        bit_idx_n    = '0;
        if (tx_start) begin
          shift_n      = data_in;
          par_bit_n    = (^data_in) ^ PARITY_ODD;
          busy_n       = 1'b1;
          serial_out_n = 1'b0;
          state_n      = START;
        end
      end
      START: begin
        if (cell_end) begin
          cnt_n        = '0;
          serial_out_n = shift[0];
          state_n      = DATA;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cell_end) begin
          cnt_n = '0;
          if (bit_idx == 3'd7) begin
            if (PARITY_EN) begin
              serial_out_n = par_bit;
              state_n      = PARITY;
            end else begin
              serial_out_n = 1'b1;
              state_n      = STOP;
            end
          end else begin
            bit_idx_n    = bit_idx + 3'd1;
            shift_n      = {1'b0, shift[7:1]};
            serial_out_n = shift[1];
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      PARITY: begin
        if (cell_end) begin
          cnt_n        = '0;
          serial_out_n = 1'b1;
          state_n      = STOP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (cell_end) begin
          cnt_n        = '0;
          serial_out_n = 1'b1;
          busy_n       = 1'b0;
          tx_done_n    = 1'b1;
          state_n      = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n      = IDLE;
        serial_out_n = 1'b1;
        busy_n       = 1'b0;
        cnt_n        = '0;
        bit_idx_n    = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (even, odd, no parity) at 10 clocks per bit,
// checked against a bit-cell waveform model and a behavioural line decoder.
module tb_uart_tx;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] st;
  logic [7:0] din;
  logic [2:0] so, bz, dn;

  int n_asrt = 0;
  int n_fail = 0;

  logic cap_line [300];
  logic cap_bsy  [300];
  logic cap_dne  [300];

  always #5 clk = ~clk;

  uart_tx #(.BASE_FREQ(1_000_000), .BAUDRATE(100_000), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_even (
    .clk(clk), .rst(rst), .tx_start(st[0]), .data_in(din),
    .serial_out(so[0]), .busy(bz[0]), .tx_done(dn[0]));

  uart_tx #(.BASE_FREQ(1_000_000), .BAUDRATE(100_000), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_odd (
    .clk(clk), .rst(rst), .tx_start(st[1]), .data_in(din),
    .serial_out(so[1]), .busy(bz[1]), .tx_done(dn[1]));

  uart_tx #(.BASE_FREQ(1_000_000), .BAUDRATE(100_000), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_nopar (
    .clk(clk), .rst(rst), .tx_start(st[2]), .data_in(din),
    .serial_out(so[2]), .busy(bz[2]), .tx_done(dn[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit pen_of(input int d);
    return d != 2;
  endfunction

  function automatic bit podd_of(input int d);
    return d == 1;
  endfunction

  function automatic int frame_len(input int d);
    return pen_of(d) ? 11 : 10;
  endfunction

  // Expected level of bit cell k of a frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k == 9 && pen_of(d)) return (($countones(b) + (podd_of(d) ? 1 : 0)) % 2) == 1;
    return 1'b1;
  endfunction

  // Sample index c holds the values seen just after active edge E+c.
  task automatic capture(input int d, input int ncyc, input int off1, input int on2, input int off2,
                         input logic [7:0] dv2, input int dch, input logic [7:0] dv);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      cap_line[c] = so[d];
      cap_bsy[c]  = bz[d];
      cap_dne[c]  = dn[d];
      if (c == dch) din = dv;
      if (c == off1) st[d] = 1'b0;
      if (c == on2) begin
        st[d] = 1'b1;
        din   = dv2;
      end
      if (c == off2) st[d] = 1'b0;
    end
  endtask

  task automatic count_window(input int lo, input int hi, output int nb, output int nd,
                              output int nov, output int nz);
    nb = 0; nd = 0; nov = 0; nz = 0;
    for (int c = lo; c < hi; c++) begin
      if (cap_bsy[c] === 1'b1) nb++;
      if (cap_dne[c] === 1'b1) nd++;
      if (cap_bsy[c] === 1'b1 && cap_dne[c] === 1'b1) nov++;
      if (cap_line[c] !== 1'b1) nz++;
    end
  endtask

  task automatic check_frame(input int d, input logic [7:0] b, input int base);
    for (int k = 0; k < frame_len(d); k++)
      chk($sformatf("cell%0d_dut%0d_byte%02h", k, d, b),
          32'(cap_line[base + k*CPB + CPB/2]), 32'(frame_bit(b, d, k)));
  endtask

  // Independent receiver: find the start edge, sample cell centres, rebuild the byte.
  task automatic rx_check(input int d, input logic [7:0] b);
    int s;
    int ones;
    logic [7:0] got;
    s = -1;
    for (int c = 0; c < 60; c++)
      if (s < 0 && cap_line[c] === 1'b0) s = c;
    chk($sformatf("rx_start_dut%0d", d), s, 0);
    if (s < 0) s = 0;
    for (int i = 0; i < 8; i++) got[i] = cap_line[s + (i+1)*CPB + CPB/2];
    chk($sformatf("rx_byte_dut%0d", d), 32'(got), 32'(b));
    if (pen_of(d)) begin
      ones = $countones(got) + (cap_line[s + 9*CPB + CPB/2] === 1'b1 ? 1 : 0);
      chk($sformatf("rx_parity_dut%0d", d), ones % 2, podd_of(d) ? 1 : 0);
    end
  endtask

  task automatic frame_test(input int d, input logic [7:0] b, input int on2, input logic [7:0] dv2);
    int n, nb, nd, nov, nz;
    n = frame_len(d) * CPB;
    @(negedge clk);
    st[d] = 1'b1;
    din   = b;
    @(posedge clk);
    capture(d, n + 30, 0, on2, on2 + 1, dv2, 1, ~b);
    check_frame(d, b, 0);
    count_window(0, n + 30, nb, nd, nov, nz);
    chk($sformatf("busy_clks_dut%0d", d), nb, n);
    chk($sformatf("done_pos_dut%0d", d), 32'(cap_dne[n]), 1);
    chk($sformatf("done_count_dut%0d", d), nd, 1);
    chk($sformatf("busy_done_overlap_dut%0d", d), nov, 0);
    count_window(n, n + 30, nb, nd, nov, nz);
    chk($sformatf("idle_after_dut%0d", d), nz, 0);
    rx_check(d, b);
  endtask

  initial begin
    int nb, nd, nov, nz, d1, d2;
    logic [10:0] exp_a5;
    rst = 1'b1;
    st  = '0;
    din = '0;
    #23;
    chk("reset_line", 32'(so), 32'(3'b111));
    chk("reset_busy", 32'(bz), 0);
    chk("reset_done", 32'(dn), 0);
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset in the middle of frames on all instances.
    @(negedge clk);
    st  = 3'b111;
    din = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    st = '0;
    repeat (36) @(negedge clk);
    chk("mid_busy_before_rst", 32'(bz), 32'(3'b111));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_line", 32'(so), 32'(3'b111));
    chk("async_rst_busy", 32'(bz), 0);
    chk("async_rst_done", 32'(dn), 0);
    @(negedge clk);
    rst = 1'b0;
    nz = 0; nb = 0; nd = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (so !== 3'b111) nz++;
      if (bz !== 3'b000) nb++;
      if (dn !== 3'b000) nd++;
    end
    chk("idle_line_200", nz, 0);
    chk("idle_busy_200", nb, 0);
    chk("idle_done_200", nd, 0);

    // 0xA5, even parity, against a literal cell pattern as well as the model.
    frame_test(0, 8'hA5, -1, 8'h00);
    exp_a5 = {1'b1, 1'b0, 8'hA5, 1'b0};
    for (int k = 0; k < 11; k++)
      chk($sformatf("a5_literal_cell%0d", k), 32'(cap_line[k*CPB + CPB/2]), 32'(exp_a5[k]));

    // Parity variants on 0x07.
    frame_test(0, 8'h07, -1, 8'h00);
    chk("par07_even", 32'(cap_line[9*CPB + CPB/2]), 1);
    frame_test(1, 8'h07, -1, 8'h00);
    chk("par07_odd", 32'(cap_line[9*CPB + CPB/2]), 0);
    frame_test(2, 8'h07, -1, 8'h00);
    chk("nopar07_stop_after_d7", 32'(cap_line[9*CPB + CPB/2]), 1);

    // Request while busy is ignored.
    frame_test(0, 8'h3C, 30, 8'hFF);

    // Back-to-back frames with tx_start held high.
    @(negedge clk);
    st[0] = 1'b1;
    din   = 8'h55;
    @(posedge clk);
    capture(0, 260, 150, -1, -1, 8'h00, 50, 8'hAA);
    check_frame(0, 8'h55, 0);
    check_frame(0, 8'hAA, 11*CPB + 1);
    chk("b2b_gap_idle", 32'(cap_line[11*CPB]), 1);
    count_window(0, 260, nb, nd, nov, nz);
    chk("b2b_busy_clks", nb, 22*CPB);
    chk("b2b_done_count", nd, 2);
    chk("b2b_overlap", nov, 0);
    d1 = -1; d2 = -1;
    for (int c = 0; c < 260; c++)
      if (cap_dne[c] === 1'b1) begin
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
    chk("b2b_done_spacing", d2 - d1, 111);
    count_window(221, 260, nb, nd, nov, nz);
    chk("b2b_no_third", nz, 0);

    // Loopback bytes and random traffic on all three variants.
    frame_test(0, 8'h00, -1, 8'h00);
    frame_test(0, 8'hFF, -1, 8'h00);
    frame_test(0, 8'h81, -1, 8'h00);
    for (int i = 0; i < 3; i++)
      for (int d = 0; d < 3; d++)
        frame_test(d, 8'($urandom), -1, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
